// File: rtl/cache_lru_tracker.sv
// cache_lru_tracker: true-LRU replacement state for a 4-way set-associative
// data cache. Supplies the victim way for the request being presented and
// updates the per-set ages one cycle later from the cache's hit/miss result.
// It also keeps saturating hit and miss counters.
//
// state | meaning
// INIT  | walking every set once to load ages {w0=0,w1=1,w2=2,w3=3}
// RUN   | accepting requests, one per cycle, with same-set bypass
module cache_lru_tracker #(
  parameter int associativity = 4,
  parameter int cache_size    = 32768,
  parameter int block_size    = 16,
  parameter int addr_width    = 32,
  parameter int cnt_width     = 32
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [addr_width-1:0] req_addr_i,
  input  logic                  cache_hit_i,
  input  logic                  cache_miss_i,
  input  logic [1:0]            cache_way_i,
  output logic [1:0]            lru_select_o,
  output logic                  ready_o,
  input  logic                  cnt_clr_i,
  output logic [cnt_width-1:0]  hit_cnt_o,
  output logic [cnt_width-1:0]  miss_cnt_o
);

  localparam int total_sets  = cache_size / (block_size * associativity);
  localparam int index_bits  = $clog2(total_sets);
  localparam int offset_bits = $clog2(block_size);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Ages packed two bits per way, way0 in [1:0]; age 0 is MRU, age 3 is LRU.
  localparam logic [7:0] init_ages = 8'b11_10_01_00;

  logic [0:0]            state;
  logic [index_bits-1:0] set_cnt;
  logic [7:0]            ages [total_sets];

  logic                  pend_valid;
  logic                  pend_we;
  logic [index_bits-1:0] pend_set;
  logic [1:0]            pend_lru;

  logic [index_bits-1:0] cur_set;
  logic [7:0]            new_ages;
  logic [7:0]            cur_ages;
  logic                  hit_only;
  logic                  miss_only;
  logic                  touch_en;
  logic [1:0]            touch_way;
  logic                  unused_addr;

  // Promote way k to MRU; only ways younger than k age by one.
  function automatic logic [7:0] touch(input logic [7:0] a, input logic [1:0] k);
    logic [1:0] ak;
    logic [7:0] r;
    r  = '0;
    ak = a[k*2 +: 2];
    for (int j = 0; j < 4; j++) begin
      if (j == int'(k))
        r[j*2 +: 2] = 2'd0;
      else if (a[j*2 +: 2] < ak)
        r[j*2 +: 2] = a[j*2 +: 2] + 2'd1;
      else
        r[j*2 +: 2] = a[j*2 +: 2];
    end
    return r;
  endfunction

  // The victim is whichever way currently holds age 3.
  function automatic logic [1:0] lru_of(input logic [7:0] a);
    logic [1:0] sel;
    sel = 2'd3;
    for (int j = 0; j < 4; j++) begin
      if (a[j*2 +: 2] == 2'd3) sel = 2'(j);
    end
    return sel;
  endfunction

  assign cur_set     = req_addr_i[offset_bits +: index_bits];
  assign unused_addr = ^{req_addr_i[addr_width-1:offset_bits+index_bits],
                         req_addr_i[offset_bits-1:0]};

  // Stage-1 decode: a write miss allocates the victim captured at request time,
  // a read miss leaves ages alone, and a hit/miss conflict is dropped.
  always_comb begin
    hit_only  = cache_hit_i & ~cache_miss_i;
    miss_only = cache_miss_i & ~cache_hit_i;
    touch_en  = pend_valid & (hit_only | (miss_only & pend_we));
    touch_way = hit_only ? cache_way_i : pend_lru;
    new_ages  = touch(ages[pend_set], touch_way);
  end

  // Victim lookup with bypass so a same-set request right behind an update sees it.
  always_comb begin
    cur_ages = ages[cur_set];
    if (touch_en && (pend_set == cur_set)) cur_ages = new_ages;
    lru_select_o = (state == RUN) ? lru_of(cur_ages) : 2'd3;
  end

  assign ready_o = (state == RUN);

  // Init walk over all sets, then stay in RUN until the next reset.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= INIT;
      set_cnt <= '0;
    end else if (state == INIT) begin
      set_cnt <= set_cnt + 1'b1;
      if (set_cnt == index_bits'(total_sets - 1)) state <= RUN;
    end
  end

  // Age array: loaded during INIT, otherwise written by the stage-1 touch.
  always_ff @(posedge clock) begin
    if (state == INIT)
      ages[set_cnt] <= init_ages;
    else if (touch_en)
      ages[pend_set] <= new_ages;
  end

  // Stage 0: capture the request and the victim offered to the cache.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
      pend_set   <= '0;
      pend_lru   <= 2'd3;
    end else begin
      pend_valid <= req_valid_i & (state == RUN);
      if (req_valid_i && state == RUN) begin
        pend_we  <= req_we_i;
        pend_set <= cur_set;
        pend_lru <= lru_select_o;
      end
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (pend_valid) begin
      if (hit_only && hit_cnt_o != '1)   hit_cnt_o  <= hit_cnt_o + 1'b1;
      if (miss_only && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_lru_tracker.sv
// tb_cache_lru_tracker: drives cache_lru_tracker with directed and random
// requests; a recency-list model per set supplies the expected victims.
module tb_cache_lru_tracker;

  localparam int n_sets  = 512;
  localparam int cnt_max = 15;

  logic        clock;
  logic        rst;
  logic        req_valid_i;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic        cache_hit_i;
  logic        cache_miss_i;
  logic [1:0]  cache_way_i;
  logic [1:0]  lru_select_o;
  logic        ready_o;
  logic        cnt_clr_i;
  logic [3:0]  hit_cnt_o;
  logic [3:0]  miss_cnt_o;

  cache_lru_tracker #(.cnt_width(4)) dut (
    .clock       (clock),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .cache_hit_i (cache_hit_i),
    .cache_miss_i(cache_miss_i),
    .cache_way_i (cache_way_i),
    .lru_select_o(lru_select_o),
    .ready_o     (ready_o),
    .cnt_clr_i   (cnt_clr_i),
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model: per set, ways ordered most- to least-recently used.
  int unsigned rec [n_sets][$];
  int  m_hit, m_miss;
  bit  m_ready;
  bit  p_valid, p_we;
  int  p_set;
  int  p_lru;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < n_sets; s++) begin
      rec[s].delete();
      for (int w = 0; w < 4; w++) rec[s].push_back(w);
    end
    m_hit = 0; m_miss = 0; m_ready = 0; p_valid = 0; p_we = 0; p_set = 0; p_lru = 3;
  endfunction

  function automatic void model_touch(input int s, input int w);
    for (int i = 0; i < rec[s].size(); i++) begin
      if (rec[s][i] == w) begin
        rec[s].delete(i);
        break;
      end
    end
    rec[s].push_front(w);
  endfunction

  // One clock of traffic, entered and left at 1 time unit after a rising edge.
  // h/m/w is the cache's answer to the previous cycle's request.
  task automatic step(input bit v, input bit we, input int set, input bit h, input bit m,
                      input logic [1:0] w, input bit clr, output logic [1:0] obs);
    logic [31:0] a;
    int exp;
    a = $urandom();
    a[12:4] = set[8:0];
    req_valid_i = v; req_we_i = we; req_addr_i = a;
    cache_hit_i = h; cache_miss_i = m; cache_way_i = w; cnt_clr_i = clr;
    if (p_valid) begin
      if (h && !m) begin
        model_touch(p_set, int'(w));
        if (m_hit < cnt_max) m_hit++;
      end else if (m && !h) begin
        if (p_we) model_touch(p_set, p_lru);
        if (m_miss < cnt_max) m_miss++;
      end
    end
    if (clr) begin m_hit = 0; m_miss = 0; end
    exp = m_ready ? int'(rec[set][3]) : 3;
    @(negedge clock);
    obs = lru_select_o;
    chk("lru_select", 32'(obs), 32'(exp));
    p_valid = v && m_ready; p_we = we; p_set = set; p_lru = exp;
    @(posedge clock); #1;
    chk("hit_cnt", 32'(hit_cnt_o), 32'(m_hit));
    chk("miss_cnt", 32'(miss_cnt_o), 32'(m_miss));
    chk("ready", 32'(ready_o), 32'(m_ready));
  endtask

  // Assert reset (entered 1 after a rising edge), release it and time INIT.
  // abort_at > 0 re-asserts reset that many cycles into INIT.
  task automatic do_reset(input int abort_at);
    int n;
    logic [31:0] a;
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_lru", 32'(lru_select_o), 32'd3);
    chk("rst_hit_cnt", 32'(hit_cnt_o), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt_o), 32'd0);
    model_reset();
    @(posedge clock); #1;
    req_valid_i = 0; cache_hit_i = 0; cache_miss_i = 0; cnt_clr_i = 0;
    @(posedge clock); #1;
    rst = 1'b1;
    n = 0;
    for (int g = 0; g < 1300; g++) begin
      @(posedge clock); #1;
      n++;
      if (ready_o) break;
      a = $urandom();
      req_valid_i = 1'($urandom_range(0, 1));
      req_addr_i  = a;
      cache_hit_i = 1'b1;
      if (n == 100) begin
        #1;
        chk("init_lru", 32'(lru_select_o), 32'd3);
      end
      if (abort_at != 0 && n == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(ready_o), 32'd0);
        @(posedge clock); #1;
        rst = 1'b1;
        n = 0;
        abort_at = 0;
      end
    end
    chk("init_len", 32'(n), 32'd512);
    chk("init_hit_cnt", 32'(hit_cnt_o), 32'd0);
    req_valid_i = 0; cache_hit_i = 0; cache_miss_i = 0;
    m_ready = 1;
  endtask

  logic [1:0] o;
  logic [1:0] seq [4];
  int s;

  initial begin
    rst = 1'b0; req_valid_i = 0; req_we_i = 0; req_addr_i = '0;
    cache_hit_i = 0; cache_miss_i = 0; cache_way_i = '0; cnt_clr_i = 0;
    model_reset();
    @(posedge clock); #1;
    do_reset(0);

    step(0, 0, 0, 0, 0, 0, 0, o);   chk("set0_lru", 32'(o), 32'd3);
    step(0, 0, 255, 0, 0, 0, 0, o); chk("set255_lru", 32'(o), 32'd3);
    step(0, 0, 511, 0, 0, 0, 0, o); chk("set511_lru", 32'(o), 32'd3);

    // Read miss leaves ages alone.
    step(1, 0, 9, 0, 0, 0, 0, o);
    step(0, 0, 9, 0, 1, 0, 0, o);
    step(0, 0, 9, 0, 0, 0, 0, o);
    chk("rd_miss_lru", 32'(o), 32'd3);
    chk("rd_miss_cnt", 32'(miss_cnt_o), 32'd1);

    // Hits to ways 0..3 of set 5, every other cycle.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 5, 0, 0, 0, 0, o);
      step(0, 0, 5, 1, 0, 2'(i), 0, o);
      seq[i] = o;
    end
    chk("age_seq0", 32'(seq[0]), 32'd3);
    chk("age_seq1", 32'(seq[1]), 32'd3);
    chk("age_seq2", 32'(seq[2]), 32'd3);
    chk("age_seq3", 32'(seq[3]), 32'd0);
    chk("age_hit_cnt", 32'(hit_cnt_o), 32'd4);

    // Back-to-back write miss then read to set 7.
    step(1, 1, 7, 0, 0, 0, 0, o);
    step(1, 0, 7, 0, 1, 0, 0, o);
    chk("bypass_lru", 32'(o), 32'd2);
    step(0, 0, 7, 0, 1, 0, 0, o);

    // Random traffic concentrated on a few sets.
    for (int i = 0; i < 2000; i++) begin
      int r;
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(10, 12));
      r = int'($urandom_range(0, 7));
      step(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), s,
           (r >= 2 && r < 5) || r == 1, (r >= 5) || r == 1,
           2'($urandom_range(0, 3)), ($urandom_range(0, 63) == 0), o);
    end

    // Saturation: clear, then 20 hits.
    step(1, 0, 20, 1, 0, 0, 1, o);
    for (int i = 0; i < 20; i++)
      step(i < 19, 0, 20 + (i % 3), 1, 0, 2'(i), 0, o);
    chk("sat_hit_cnt", 32'(hit_cnt_o), 32'd15);

    // Clear coincides with a stage-1 hit.
    step(1, 0, 3, 0, 0, 0, 0, o);
    step(0, 0, 3, 1, 0, 1, 1, o);
    chk("clr_hit_cnt", 32'(hit_cnt_o), 32'd0);

    // Reset one cycle after a write request, with its miss response presented.
    step(1, 1, 7, 0, 0, 0, 0, o);
    cache_miss_i = 1'b1;
    do_reset(0);
    step(0, 0, 7, 0, 0, 0, 0, o);
    chk("rst_run_lru", 32'(o), 32'd3);
    chk("rst_run_miss", 32'(miss_cnt_o), 32'd0);

    // Reset 100 cycles into INIT.
    do_reset(100);
    step(1, 1, 4, 0, 0, 0, 0, o);
    step(0, 0, 4, 0, 1, 0, 0, o);
    chk("post_abort_lru", 32'(o), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
